program_result_monitor: RTL
===========================

Name: program_result_monitor

Overview:
Synthesizable pass/fail monitor that snoops the core's data-memory write bus while a program runs. It holds NUM_CHECKS programmable (address, expected value) entries and compares each write to those addresses. It reports completion, pass/fail, failure cause and cycle count, so simulation benches and FPGA builds can check multiple results, time out and detect instruction exhaustion without bench-only hierarchical peeking.

Parameters:
BIT_COUNT, 32, data width of MemWriteData and expected values.
ADR_WIDTH, 32, width of MemAdr and entry addresses.
NUM_CHECKS, 4, number of result-check entries (1..16).
TIMEOUT_CYCLES, 10000, RUN cycles before timeout failure.
CNT_WIDTH, 32, width of cycle_count; saturates at all-ones.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: clear progress, enter RUN
cfg_we  in  1  write one check entry (honoured outside RUN only)
cfg_idx  in  $clog2(NUM_CHECKS)  entry index
cfg_en  in  1  entry enable value
cfg_adr  in  ADR_WIDTH  entry watch address
cfg_data  in  BIT_COUNT  entry expected value
MemEn  in  1  data-memory access valid
MemWriteEn  in  1  access is a write
MemAdr  in  ADR_WIDTH  access address
MemWriteData  in  BIT_COUNT  write data
instr_valid  in  1  fetched instruction is defined; low means out of instructions
done  out  1  monitor in PASS or FAIL
pass  out  1  monitor in PASS
fail_code  out  2  0 NONE, 1 MISMATCH, 2 NO_INSTR, 3 TIMEOUT
fail_idx  out  $clog2(NUM_CHECKS)  entry that mismatched
fail_data  out  BIT_COUNT  observed data for the mismatch
seen  out  NUM_CHECKS  per-entry matched flags
cycle_count  out  CNT_WIDTH  cycles spent in RUN

Behaviour:
- Reset (reset low, asynchronous): state IDLE; every output 0; entries disabled with address/data 0.
- States: IDLE, RUN, PASS, FAIL. start in any state goes to RUN next edge, clearing seen, fail_*, cycle_count. start takes priority over every other event that cycle.
- IDLE/PASS/FAIL: a cfg_we writes entry cfg_idx next edge. A cfg_we in RUN is ignored.
- RUN, per cycle: cycle_count increments, saturating. A hit is MemEn & MemWriteEn & MemAdr == entry address with the entry enabled. On a hit to an unseen entry with matching data, its seen bit sets. On a hit to an unseen entry with differing data, the block goes to FAIL: code MISMATCH, fail_idx = lowest mismatching index, fail_data = MemWriteData.
- Several entries may share an address. All are evaluated in the same cycle.
- Disabled entries count as seen. If every entry is seen or disabled, including newly set bits this cycle, the next state is PASS. A start with zero enabled entries therefore reaches PASS after exactly one RUN cycle.
- instr_valid low in RUN goes to FAIL with code NO_INSTR.
- cycle_count reaching TIMEOUT_CYCLES-1 in RUN goes to FAIL with code TIMEOUT.
- Same-cycle priority: MISMATCH > PASS > NO_INSTR > TIMEOUT.
- Latency: the write sampled at edge N produces the state, done, pass and fail_* updates at edge N.
- PASS/FAIL are sticky until start or reset. Bus activity there is ignored and cycle_count freezes.
- Reset mid-RUN aborts immediately and clears everything, including entries.

Optional Feature:
Macro: MONITOR_REWRITE_CHECK_EN.
- Defined: a hit to an already-seen entry must carry the same data. A differing value goes to FAIL with code MISMATCH and that entry's index.
- Undefined: hits to seen entries are ignored.

Decomposition:
- Package monitor_pkg: state enum (IDLE, RUN, PASS, FAIL), fail_code enum, FAIL_CODE_WIDTH = 2.
- Sub-module result_check_entry, instantiated NUM_CHECKS times. It holds en/adr/expected, the seen flag and the config write logic. It outputs hit, match and seen.
- The top level holds the FSM, priority encoding of mismatch index, counter and timeout compare.

Test Plan:
- Entry0 = (0xC, 0x0f) enabled, others disabled; start; write 0x0f to 0xC at RUN cycle 5 -> pass=1, done=1, cycle_count=6.
- Same config; write 0x0e to 0xC -> done=1, pass=0, fail_code=1, fail_idx=0, fail_data=0x0e.
- Four entries (0x10..0x1C, values 1..4) written in reverse order, one write to unrelated 0x20 -> seen fills 1000, 1100, 1110, then pass; write to 0x20 has no effect.
- TIMEOUT_CYCLES=20, no hits -> FAIL with fail_code=3 at cycle 20. A separate run drops instr_valid at cycle 7 -> fail_code=2. A same-cycle correct final write plus instr_valid low -> PASS.
- With the macro defined: correct write to 0xC, then 0x11 to 0xC in the same cycle that completes the other entries -> fail_code=1. Without the macro -> pass.
- Reset low for one cycle mid-RUN -> all outputs 0 asynchronously and entries cleared. cfg_we pulsed during RUN -> entry unchanged after the run.

Source files
------------

// File: rtl/monitor_pkg.sv
// Shared types for the program result monitor: FSM states and failure codes.
package monitor_pkg;

  localparam int FAIL_CODE_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } mon_state_e;

  typedef enum logic [FAIL_CODE_WIDTH-1:0] {
    FC_NONE     = 2'd0,
    FC_MISMATCH = 2'd1,
    FC_NO_INSTR = 2'd2,
    FC_TIMEOUT  = 2'd3
  } fail_code_e;

  // Index width that stays legal for a single-entry build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_check_entry.sv
// One programmable (address, expected value) check entry with its matched flag.
module result_check_entry
  import monitor_pkg::*;
#(
  parameter int BIT_COUNT = 32,
  parameter int ADR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_wr,
  input  logic                 cfg_en,
  input  logic [ADR_WIDTH-1:0] cfg_adr,
  input  logic [BIT_COUNT-1:0] cfg_data,
  input  logic                 clr_seen,
  input  logic                 run,
  input  logic                 mem_wr,
  input  logic [ADR_WIDTH-1:0] mem_adr,
  input  logic [BIT_COUNT-1:0] mem_data,
  output logic                 en,
  output logic                 hit,
  output logic                 match,
  output logic                 seen
);

  logic [ADR_WIDTH-1:0] adr;
  logic [BIT_COUNT-1:0] expected;

  assign hit   = en & mem_wr & (mem_adr == adr);
  assign match = (mem_data == expected);

  // Entry configuration and matched flag; a clear (start) beats a same-cycle match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en       <= 1'b0;
      adr      <= '0;
      expected <= '0;
      seen     <= 1'b0;
    end else begin
      if (cfg_wr) begin
        en       <= cfg_en;
        adr      <= cfg_adr;
        expected <= cfg_data;
      end
      if (clr_seen)
        seen <= 1'b0;
      else if (run && hit && match)
        seen <= 1'b1;
    end
  end

endmodule

// File: rtl/program_result_monitor.sv
// Pass/fail monitor snooping the data-memory write bus during a program run.
// Optional: define MONITOR_REWRITE_CHECK_EN to also fail when an already
// matched entry is rewritten with a different value.
module program_result_monitor
  import monitor_pkg::*;
#(
  parameter int BIT_COUNT      = 32,
  parameter int ADR_WIDTH      = 32,
  parameter int NUM_CHECKS     = 4,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int CNT_WIDTH      = 32,
  localparam int IDX_W         = idx_width(NUM_CHECKS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       cfg_we,
  input  logic [IDX_W-1:0]           cfg_idx,
  input  logic                       cfg_en,
  input  logic [ADR_WIDTH-1:0]       cfg_adr,
  input  logic [BIT_COUNT-1:0]       cfg_data,
  input  logic                       MemEn,
  input  logic                       MemWriteEn,
  input  logic [ADR_WIDTH-1:0]       MemAdr,
  input  logic [BIT_COUNT-1:0]       MemWriteData,
  input  logic                       instr_valid,
  output logic                       done,
  output logic                       pass,
  output logic [FAIL_CODE_WIDTH-1:0] fail_code,
  output logic [IDX_W-1:0]           fail_idx,
  output logic [BIT_COUNT-1:0]       fail_data,
  output logic [NUM_CHECKS-1:0]      seen,
  output logic [CNT_WIDTH-1:0]       cycle_count
);

  mon_state_e state, state_nxt;
  fail_code_e fc_q, fc_nxt;

  logic [NUM_CHECKS-1:0] en, hit, match, mm, seen_nxt;
  logic [IDX_W-1:0]      mm_idx;
  logic                  in_run, mem_wr, cfg_ok, all_ok, timeout;

  assign in_run  = (state == ST_RUN);
  assign mem_wr  = MemEn & MemWriteEn;
  assign cfg_ok  = cfg_we & ~in_run & ~start;
  assign timeout = (cycle_count == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_entry
    result_check_entry #(
      .BIT_COUNT(BIT_COUNT),
      .ADR_WIDTH(ADR_WIDTH)
    ) u_entry (
      .clk      (clk),
      .reset    (reset),
      .cfg_wr   (cfg_ok && (cfg_idx == IDX_W'(i))),
      .cfg_en   (cfg_en),
      .cfg_adr  (cfg_adr),
      .cfg_data (cfg_data),
      .clr_seen (start),
      .run      (in_run),
      .mem_wr   (mem_wr),
      .mem_adr  (MemAdr),
      .mem_data (MemWriteData),
      .en       (en[i]),
      .hit      (hit[i]),
      .match    (match[i]),
      .seen     (seen[i])
    );
  end

`ifdef MONITOR_REWRITE_CHECK_EN
  assign mm = hit & ~match;
`else
  assign mm = hit & ~match & ~seen;
`endif

  // Seen flags including this cycle's matches; disabled entries count as done.
  assign seen_nxt = seen | (hit & match);
  assign all_ok   = &(seen_nxt | ~en);

  // Lowest mismatching entry index.
  always_comb begin
    mm_idx = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--)
      if (mm[i]) mm_idx = IDX_W'(i);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and failure cause; start wins, then MISMATCH > PASS > NO_INSTR > TIMEOUT.
  always_comb begin
    state_nxt = state;
    fc_nxt    = fc_q;
    if (start) begin
      state_nxt = ST_RUN;
      fc_nxt    = FC_NONE;
    end else if (in_run) begin
      if (|mm) begin
        state_nxt = ST_FAIL;
        fc_nxt    = FC_MISMATCH;
      end else if (all_ok) begin
        state_nxt = ST_PASS;
      end else if (!instr_valid) begin
        state_nxt = ST_FAIL;
        fc_nxt    = FC_NO_INSTR;
      end else if (timeout) begin
        state_nxt = ST_FAIL;
        fc_nxt    = FC_TIMEOUT;
      end
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    done = (state == ST_PASS) || (state == ST_FAIL);
    pass = (state == ST_PASS);
  end

  // Failure details and saturating run-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fc_q        <= FC_NONE;
      fail_idx    <= '0;
      fail_data   <= '0;
      cycle_count <= '0;
    end else if (start) begin
      fc_q        <= FC_NONE;
      fail_idx    <= '0;
      fail_data   <= '0;
      cycle_count <= '0;
    end else if (in_run) begin
      fc_q <= fc_nxt;
      if (|mm) begin
        fail_idx  <= mm_idx;
        fail_data <= MemWriteData;
      end
      if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
    end
  end

  assign fail_code = fc_q;

endmodule
